alu_arbiter: RTL and testbench

//  Shares one ALU instance between NUM_REQ requesters (e.g. main datapath, address-gen,

---
 rtl/alu_arbiter.sv | 116 +++++++++++
 tb/tb_alu_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between NUM_REQ requesters.
// Results are held in a one-entry register and returned with the requester id.
module alu_arbiter #(
  parameter  int DATAWIDTH = 32,
  parameter  int NUM_REQ   = 2,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_srca_i,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_srcb_i,
  input  logic [NUM_REQ*4-1:0]         req_ctrl_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [IDW-1:0]               resp_id_o,
  output logic [DATAWIDTH-1:0]         resp_result_o,
  output logic                         resp_zero_o,
  output logic                         dbg_state_o,
  output logic [IDW-1:0]               dbg_rr_o
);

  // Handshake: a request transfers on a rising edge where req_valid_i[k] and
  // req_ready_o[k] are both high; a response transfers where resp_valid_o and
  // resp_ready_i are both high. Valid never waits on ready on either side.

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t               r_state;
  logic [IDW-1:0]       r_rr;
  logic [IDW-1:0]       r_id;
  logic [DATAWIDTH-1:0] r_result;
  logic                 r_zero;

  logic                 w_can_accept;
  logic                 w_grant_vld;
  logic [IDW-1:0]       w_grant_id;
  logic [IDW-1:0]       w_scan_idx;
  int                   w_scan_sum;
  logic                 w_accept;
  logic [IDW-1:0]       w_rr_next;
  logic [DATAWIDTH-1:0] w_opa;
  logic [DATAWIDTH-1:0] w_opb;
  logic [3:0]           w_ctrl;
  logic [DATAWIDTH-1:0] w_alu;

  // Gating with rst_n_i keeps every ready low while reset is held.
  assign w_can_accept = rst_n_i && ((r_state == ST_EMPTY) || resp_ready_i);

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_scan_idx  = '0;
    w_scan_sum  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan_sum = int'(r_rr) + i;
      if (w_scan_sum >= NUM_REQ) w_scan_sum = w_scan_sum - NUM_REQ;
      w_scan_idx = IDW'(w_scan_sum);
      if (!w_grant_vld && req_valid_i[w_scan_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_scan_idx;
      end
    end
  end

  assign w_accept    = w_can_accept && w_grant_vld;
  assign req_ready_o = w_accept ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign w_rr_next   = (w_grant_id == IDW'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;

  assign w_opa  = req_srca_i[w_grant_id*DATAWIDTH +: DATAWIDTH];
  assign w_opb  = req_srcb_i[w_grant_id*DATAWIDTH +: DATAWIDTH];
  assign w_ctrl = req_ctrl_i[w_grant_id*4 +: 4];

  always_comb begin
    w_alu = '0;
    case (w_ctrl)
      4'b0000: w_alu = w_opa + w_opb;
      4'b0001: w_alu = w_opa - w_opb;
      4'b0010: w_alu = w_opa & w_opb;
      4'b0011: w_alu = w_opa | w_opb;
      4'b0101: w_alu = {{(DATAWIDTH-1){1'b0}}, ($signed(w_opa) < $signed(w_opb))};
      4'b0110: w_alu = {{(DATAWIDTH-1){1'b0}}, (w_opa < w_opb)};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_EMPTY;
      r_rr     <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_state  <= ST_FULL;
      r_rr     <= w_rr_next;
      r_id     <= w_grant_id;
      r_result <= w_alu;
      r_zero   <= (w_alu == '0);
    end else if ((r_state == ST_FULL) && resp_ready_i) begin
      r_state  <= ST_EMPTY;
    end
  end

  assign resp_valid_o  = (r_state == ST_FULL);
  assign resp_id_o     = r_id;
  assign resp_result_o = r_result;
  assign resp_zero_o   = r_zero;
  assign dbg_state_o   = r_state;
  assign dbg_rr_o      = r_rr;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random bench for alu_arbiter with a negedge monitor feeding
// an expected-result queue.
`timescale 1ns/100ps
module tb_alu_arbiter;
  localparam int DW  = 32;
  localparam int NR  = 2;
  localparam int IDW = 1;
  localparam int EW  = IDW + 1 + DW;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  srca;
  logic [NR*DW-1:0]  srcb;
  logic [NR*4-1:0]   ctrl;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [DW-1:0]     resp_result;
  logic              resp_zero;
  logic              dbg_state;
  logic [IDW-1:0]    dbg_rr;

  logic [EW-1:0]     exp_q[$];
  int                n_vec;
  int                n_err;
  logic              m_full;
  logic [IDW-1:0]    m_rr;
  int                wait_acc[NR];

  alu_arbiter #(.DATAWIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_srca_i(srca), .req_srcb_i(srcb), .req_ctrl_i(ctrl),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_result_o(resp_result), .resp_zero_o(resp_zero),
    .dbg_state_o(dbg_state), .dbg_rr_o(dbg_rr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] alu_model(input logic [3:0] c, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd5:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6:    return (a < b) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  // driver tasks
  task automatic set_req(input int k, input logic v, input logic [3:0] c,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid[k]     = v;
    ctrl[k*4 +: 4]   = c;
    srca[k*DW +: DW] = a;
    srcb[k*DW +: DW] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_rr   = '0;
    exp_q.delete();
    for (int k = 0; k < NR; k++) wait_acc[k] = 0;
  endtask

  // monitor / scoreboard: runs between edges when inputs are settled
  logic [NR-1:0] mon_rdy;
  logic          mon_can;
  int            mon_idx;
  int            mon_acc;
  logic [DW-1:0] mon_r;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      mon_can = !m_full || resp_ready;
      mon_rdy = '0;
      if (mon_can) begin
        for (int i = 0; i < NR; i++) begin
          mon_idx = (int'(m_rr) + i) % NR;
          if (mon_rdy == '0 && req_valid[mon_idx]) mon_rdy[mon_idx] = 1'b1;
        end
      end
      chk("grant", req_ready, mon_rdy);
      chk("resp_valid", resp_valid, m_full);
      if (m_full && resp_ready) begin
        chk("resp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("resp", {resp_id, resp_zero, resp_result}, mon_e);
        end
      end
      mon_acc = -1;
      for (int k = 0; k < NR; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          mon_acc = k;
          mon_r = alu_model(ctrl[k*4 +: 4], srca[k*DW +: DW], srcb[k*DW +: DW]);
          exp_q.push_back({IDW'(k), (mon_r == '0), mon_r});
          m_rr = (k == NR - 1) ? '0 : IDW'(k + 1);
        end
      end
      for (int j = 0; j < NR; j++) begin
        if (j == mon_acc) begin
          chk("fairness", wait_acc[j] < NR, 1);
          wait_acc[j] = 0;
        end else if (!req_valid[j]) begin
          wait_acc[j] = 0;
        end else if (mon_acc >= 0) begin
          wait_acc[j]++;
        end
      end
      if (mon_acc >= 0) m_full = 1'b1;
      else if (m_full && resp_ready) m_full = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  logic [NR-1:0]  r_v;
  logic [3:0]     r_c[NR];
  logic [DW-1:0]  r_a[NR];
  logic [DW-1:0]  r_b[NR];
  logic [NR-1:0]  acc;
  logic [NR-1:0]  exp_rdy;
  int             gk;

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    rst_n = 1'b0; resp_ready = 1'b0;
    req_valid = '0; srca = '0; srcb = '0; ctrl = '0;

    // reset state, with requests pending
    #2;
    req_valid = 2'b11;
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_result", resp_result, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_zero", resp_zero, 0);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rr", dbg_rr, 0);
    req_valid = '0;
    #9 rst_n = 1'b1;
    tick();

    // 1 single add
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    resp_ready = 1'b1;
    #1 chk("t1_ready", req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("t1_valid", resp_valid, 1);
    chk("t1_result", resp_result, 12);
    chk("t1_id", resp_id, 0);
    chk("t1_zero", resp_zero, 0);

    // 2 contention, rr now points at requester 1
    set_req(0, 1'b1, 4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    set_req(1, 1'b1, 4'd3, 32'h0000_00A0, 32'h0000_000B);
    exp_rdy = 2'b10;
    for (int i = 0; i < 8; i++) begin
      #1 chk("t2_ready", req_ready, exp_rdy);
      gk = exp_rdy[1] ? 1 : 0;
      tick();
      chk("t2_id", resp_id, gk);
      chk("t2_valid", resp_valid, 1);
      set_req(gk, 1'b1, 4'($urandom_range(0, 6)), $urandom, $urandom);
      exp_rdy = ~exp_rdy;
    end
    req_valid = '0;
    tick();

    // 3 backpressure with a zero result held
    set_req(1, 1'b1, 4'd1, 32'd9, 32'd9);
    resp_ready = 1'b0;
    tick();
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(0, 1'b1, 4'd0, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_ready", req_ready, 2'b00);
      chk("t3_valid", resp_valid, 1);
      chk("t3_result", resp_result, 0);
      chk("t3_zero", resp_zero, 1);
      chk("t3_id", resp_id, 1);
      tick();
    end
    resp_ready = 1'b1;
    #1 chk("t3_release_ready", req_ready, 2'b01);
    tick();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("t3_result2", resp_result, 7);
    chk("t3_id2", resp_id, 0);

    // 4 wrap and unused ctrl code
    set_req(0, 1'b1, 4'd1, 32'd0, 32'd1);
    #1 chk("t4_ready0", req_ready, 2'b01);
    tick();
    chk("t4_wrap", resp_result, 32'hFFFF_FFFF);
    chk("t4_wrap_zero", resp_zero, 0);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 4'b0100, 32'd123, 32'd456);
    #1 chk("t4_ready1", req_ready, 2'b10);
    tick();
    chk("t4_bad_result", resp_result, 0);
    chk("t4_bad_zero", resp_zero, 1);
    chk("t4_bad_id", resp_id, 1);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();

    // 5 reset while holding a result; rr left pointing at requester 1
    set_req(1, 1'b1, 4'd0, 32'd1, 32'd1);
    resp_ready = 1'b0;
    tick();
    chk("t5_full", resp_valid, 1);
    chk("t5_rr", dbg_rr, 0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    resp_ready = 1'b1;
    tick();
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
    resp_ready = 1'b0;
    tick();
    chk("t5_full2", resp_valid, 1);
    set_req(1, 1'b1, 4'd0, 32'd10, 32'd20);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_valid", resp_valid, 0);
    chk("t5_rst_result", resp_result, 0);
    chk("t5_rst_zero", resp_zero, 0);
    chk("t5_rst_ready", req_ready, 2'b00);
    chk("t5_rst_rr", dbg_rr, 0);
    resp_ready = 1'b1;
    #1 rst_n = 1'b1;
    #1 chk("t5_first", req_ready, 2'b01);
    tick();
    chk("t5_id", resp_id, 0);
    chk("t5_result", resp_result, 2);
    req_valid = '0;
    tick();

    // 6 random traffic
    r_v = '0; acc = '0;
    for (int k = 0; k < NR; k++) begin
      r_c[k] = '0; r_a[k] = '0; r_b[k] = '0;
    end
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (!r_v[k] || acc[k]) begin
          r_v[k] = ($urandom_range(0, 3) != 0);
          r_c[k] = 4'($urandom_range(0, 15));
          r_a[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
          r_b[k] = ($urandom_range(0, 3) == 0) ? r_a[k] : $urandom;
        end
        set_req(k, r_v[k], r_c[k], r_a[k], r_b[k]);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      #1 acc = req_valid & req_ready;
      tick();
    end

    // drain
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("drain_queue", exp_q.size(), 0);
    tick();
    chk("drain_valid", resp_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
